// File: rtl/prog_loader.sv
// Byte-stream program loader: fills instruction memory from a framed image and holds the core in reset meanwhile.
// Optional trailing checksum byte is enabled by defining PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HDR_LO = 3'd1,
        HDR_HI = 3'd2,
        DATA   = 3'd3,
        WRITE  = 3'd4,
`ifdef PROG_LOADER_CHECKSUM_EN
        CSUM   = 3'd5,
`endif
        DONE   = 3'd6,
        ERR    = 3'd7
    } state_t;

`ifdef PROG_LOADER_CHECKSUM_EN
    localparam state_t AFTER_DATA = CSUM;
`else
    localparam state_t AFTER_DATA = DONE;
`endif

    localparam logic [ADDR_W:0]   WORD_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t              state_r;
    state_t              state_s;
    logic                start_s;
    logic                accept_s;
    logic [15:0]         len_hdr_s;
    logic [ADDR_W:0]     words_next_s;
    logic                last_word_s;
    logic                in_ready_r;
    logic                imem_we_r;
    logic [ADDR_W-1:0]   imem_addr_r;
    logic [31:0]         imem_wdata_r;
    logic                core_rst_r;
    logic                busy_r;
    logic                done_r;
    logic                err_r;
    logic [ADDR_W:0]     words_loaded_r;
    logic [15:0]         len_r;
    logic [1:0]          byte_idx_r;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]          sum_r;
    logic                csum_ok_s;
`endif

    // States in which a byte may be consumed from the stream.
    function automatic logic rx_state(input state_t s);
        case (s)
            HDR_LO, HDR_HI, DATA: rx_state = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
            CSUM:                 rx_state = 1'b1;
`endif
            default:              rx_state = 1'b0;
        endcase
    endfunction

    assign accept_s     = in_valid & in_ready_r;
    assign len_hdr_s    = {in_data, len_r[7:0]};
    assign words_next_s = words_loaded_r + WORD_ONE;
    assign last_word_s  = (16'(words_next_s) == len_r);
`ifdef PROG_LOADER_CHECKSUM_EN
    assign csum_ok_s    = ((sum_r + in_data) == 8'h00);
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; start is only honoured while no load is running.
    always_comb begin
        state_s = state_r;
        start_s = 1'b0;
        case (state_r)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_s = HDR_LO;
                    start_s = 1'b1;
                end else begin
                    state_s = state_r;
                end
            end
            HDR_LO: begin
                if (accept_s) state_s = HDR_HI;
                else          state_s = HDR_LO;
            end
            HDR_HI: begin
                if (!accept_s)                  state_s = HDR_HI;
                else if (len_hdr_s > 16'(DEPTH)) state_s = ERR;
                else if (len_hdr_s == 16'd0)     state_s = AFTER_DATA;
                else                             state_s = DATA;
            end
            DATA: begin
                if (accept_s && (byte_idx_r == 2'd3)) state_s = WRITE;
                else                                  state_s = DATA;
            end
            WRITE: begin
                if (last_word_s) state_s = AFTER_DATA;
                else             state_s = DATA;
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            CSUM: begin
                if (!accept_s)     state_s = CSUM;
                else if (csum_ok_s) state_s = DONE;
                else                state_s = ERR;
            end
`endif
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Handshake, strobe and status outputs registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r <= 1'b0;
            imem_we_r  <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            in_ready_r <= rx_state(state_s);
            imem_we_r  <= (state_s == WRITE);
            busy_r     <= rx_state(state_s) | (state_s == WRITE);
        end
    end

    // Word assembly, address/count tracking and sticky completion flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_addr_r    <= {ADDR_W{1'b0}};
            imem_wdata_r   <= 32'h0000_0000;
            core_rst_r     <= 1'b0;
            done_r         <= 1'b0;
            err_r          <= 1'b0;
            words_loaded_r <= {(ADDR_W+1){1'b0}};
            len_r          <= 16'h0000;
            byte_idx_r     <= 2'd0;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_r          <= 8'h00;
`endif
        end else if (start_s) begin
            imem_addr_r    <= {ADDR_W{1'b0}};
            core_rst_r     <= 1'b1;
            done_r         <= 1'b0;
            err_r          <= 1'b0;
            words_loaded_r <= {(ADDR_W+1){1'b0}};
            byte_idx_r     <= 2'd0;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_r          <= 8'h00;
`endif
        end else begin
            case (state_r)
                HDR_LO: if (accept_s) len_r[7:0]  <= in_data;
                HDR_HI: if (accept_s) len_r[15:8] <= in_data;
                DATA: begin
                    if (accept_s) begin
                        imem_wdata_r[{byte_idx_r, 3'b000} +: 8] <= in_data;
                        byte_idx_r <= byte_idx_r + 2'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
                        sum_r <= sum_r + in_data;
`endif
                    end
                end
                WRITE: begin
                    imem_addr_r    <= imem_addr_r + ADDR_ONE;
                    words_loaded_r <= words_next_s;
                end
                default: len_r <= len_r;
            endcase
            // Release the core only on a complete image; an error keeps it held.
            if ((state_s == DONE) && (state_r != DONE)) begin
                done_r     <= 1'b1;
                core_rst_r <= 1'b0;
            end
            if ((state_s == ERR) && (state_r != ERR)) begin
                err_r <= 1'b1;
            end
        end
    end

    assign in_ready     = in_ready_r;
    assign imem_we      = imem_we_r;
    assign imem_addr    = imem_addr_r;
    assign imem_wdata   = imem_wdata_r;
    assign core_rst     = core_rst_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign err          = err_r;
    assign words_loaded = words_loaded_r;

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader; checksum scenarios follow PROG_LOADER_CHECKSUM_EN.
module tb_prog_loader;
    localparam int DEPTH  = 256;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_rst;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   words_loaded;

    int tests = 0;
    int fails = 0;
    logic [ADDR_W-1:0] wr_addr[$];
    logic [31:0]       wr_data[$];
    int ready_viol = 0;
    int crst_viol  = 0;

    prog_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .core_rst(core_rst), .busy(busy), .done(done), .err(err), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    // Write log plus protocol watchers, sampled mid-cycle.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wr_addr.push_back(imem_addr);
            wr_data.push_back(imem_wdata);
            if (in_ready !== 1'b0) ready_viol++;
        end
        if (busy === 1'b1 && core_rst !== 1'b1) crst_viol++;
    end

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        ready_viol = 0;
        crst_viol  = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int t = 0;
        if (gap) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            tests++; fails++;
            $display("FAIL byte_timeout in_ready=%b want 1 for byte %h", in_ready, b);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] f[$], input bit gap, input bit add_csum);
        logic [7:0] sum = 8'h00;
        foreach (f[i]) begin
            send_byte(f[i], gap);
            if (i >= 2) sum = sum + f[i];
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        if (add_csum) send_byte(8'h00 - sum, gap);
`endif
    endtask

    task automatic wait_not_busy();
        int t = 0;
        while (busy !== 1'b0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            tests++; fails++;
            $display("FAIL busy_timeout busy=%b want 0", busy);
        end
    endtask

    task automatic test_reset();
        #12;
        tests++;
        if ({in_ready, imem_we, imem_addr, imem_wdata, core_rst, busy, done, err, words_loaded} !== '0) begin
            fails++;
            $display("FAIL reset_values rdy=%b we=%b addr=%h wd=%h crst=%b busy=%b done=%b err=%b wl=%0d want all 0",
                     in_ready, imem_we, imem_addr, imem_wdata, core_rst, busy, done, err, words_loaded);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_load(input bit gap, input bit start_mid, input string name);
        logic [7:0] f[$];
        f = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
        clear_log();
        pulse_start();
        tests++;
        if (core_rst !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
            fails++;
            $display("FAIL %s_start crst=%b busy=%b done=%b want 1 1 0", name, core_rst, busy, done);
        end
        if (start_mid) begin
            send_frame(f[0:3], gap, 1'b0);
            pulse_start();
            send_frame(f[4:9], gap, 1'b0);
`ifdef PROG_LOADER_CHECKSUM_EN
            send_byte(8'h20, gap);
`endif
        end else begin
            send_frame(f, gap, 1'b1);
        end
        wait_not_busy();
        tests++;
        if (wr_addr.size() !== 2) begin
            fails++;
            $display("FAIL %s_wcount got=%0d want 2", name, wr_addr.size());
        end else begin
            tests++;
            if (wr_addr[0] !== 8'd0 || wr_data[0] !== 32'h0010_0513) begin
                fails++;
                $display("FAIL %s_w0 got=%h:%h want 00:00100513", name, wr_addr[0], wr_data[0]);
            end
            tests++;
            if (wr_addr[1] !== 8'd1 || wr_data[1] !== 32'h0020_0593) begin
                fails++;
                $display("FAIL %s_w1 got=%h:%h want 01:00200593", name, wr_addr[1], wr_data[1]);
            end
        end
        tests++;
        if (done !== 1'b1 || err !== 1'b0 || core_rst !== 1'b0 || words_loaded !== 9'd2) begin
            fails++;
            $display("FAIL %s_end done=%b err=%b crst=%b wl=%0d want 1 0 0 2", name, done, err, core_rst, words_loaded);
        end
        tests++;
        if (ready_viol !== 0 || crst_viol !== 0) begin
            fails++;
            $display("FAIL %s_protocol rdy_in_write=%0d crst_low_busy=%0d want 0 0", name, ready_viol, crst_viol);
        end
    endtask

    task automatic test_len_bounds();
        logic [7:0] f[$];
        clear_log();
        pulse_start();
        f = '{8'h01, 8'h01};
        send_frame(f, 1'b0, 1'b0);
        tests++;
        if (err !== 1'b1 || done !== 1'b0 || busy !== 1'b0 || core_rst !== 1'b1) begin
            fails++;
            $display("FAIL len257 err=%b done=%b busy=%b crst=%b want 1 0 0 1", err, done, busy, core_rst);
        end
        repeat (4) @(negedge clk);
        tests++;
        if (core_rst !== 1'b1 || in_ready !== 1'b0 || wr_addr.size() !== 0) begin
            fails++;
            $display("FAIL len257_hold crst=%b rdy=%b writes=%0d want 1 0 0", core_rst, in_ready, wr_addr.size());
        end
        pulse_start();
        f = '{8'h00, 8'h01};
        send_frame(f, 1'b0, 1'b0);
        tests++;
        if (err !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL len256 err=%b busy=%b rdy=%b want 0 1 1", err, busy, in_ready);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_log();
        pulse_start();
        f = '{8'h00, 8'h00};
        send_frame(f, 1'b0, 1'b1);
        wait_not_busy();
        tests++;
        if (done !== 1'b1 || err !== 1'b0 || core_rst !== 1'b0 || words_loaded !== 9'd0 || wr_addr.size() !== 0) begin
            fails++;
            $display("FAIL len0 done=%b err=%b crst=%b wl=%0d writes=%0d want 1 0 0 0 0",
                     done, err, core_rst, words_loaded, wr_addr.size());
        end
    endtask

    task automatic test_reset_mid_load();
        logic [7:0] f[$];
        pulse_start();
        f = '{8'h03, 8'h00, 8'haa, 8'hbb, 8'hcc, 8'hdd};
        send_frame(f, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({in_ready, imem_we, imem_addr, imem_wdata, core_rst, busy, done, err, words_loaded} !== '0) begin
            fails++;
            $display("FAIL midreset rdy=%b we=%b addr=%h wd=%h crst=%b busy=%b done=%b err=%b wl=%0d want all 0",
                     in_ready, imem_we, imem_addr, imem_wdata, core_rst, busy, done, err, words_loaded);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_log();
        pulse_start();
        f = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        send_frame(f, 1'b0, 1'b1);
        wait_not_busy();
        tests++;
        if (wr_addr.size() !== 1) begin
            fails++;
            $display("FAIL reload_count got=%0d want 1", wr_addr.size());
        end else if (wr_addr[0] !== 8'd0 || wr_data[0] !== 32'h4433_2211) begin
            fails++;
            $display("FAIL reload_w0 got=%h:%h want 00:44332211", wr_addr[0], wr_data[0]);
        end
        tests++;
        if (done !== 1'b1 || words_loaded !== 9'd1) begin
            fails++;
            $display("FAIL reload_end done=%b wl=%0d want 1 1", done, words_loaded);
        end
    endtask

    task automatic test_checksum();
        logic [7:0] f[$];
`ifdef PROG_LOADER_CHECKSUM_EN
        pulse_start();
        f = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'hf6};
        send_frame(f, 1'b0, 1'b0);
        wait_not_busy();
        tests++;
        if (done !== 1'b1 || err !== 1'b0 || core_rst !== 1'b0) begin
            fails++;
            $display("FAIL csum_good done=%b err=%b crst=%b want 1 0 0", done, err, core_rst);
        end
        pulse_start();
        f[6] = 8'hf5;
        send_frame(f, 1'b0, 1'b0);
        wait_not_busy();
        tests++;
        if (done !== 1'b0 || err !== 1'b1 || core_rst !== 1'b1) begin
            fails++;
            $display("FAIL csum_bad done=%b err=%b crst=%b want 0 1 1", done, err, core_rst);
        end
`else
        pulse_start();
        f = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
        send_frame(f, 1'b0, 1'b0);
        wait_not_busy();
        in_valid = 1'b1;
        in_data  = 8'hf6;
        repeat (3) begin
            @(negedge clk);
            tests++;
            if (in_ready !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
                fails++;
                $display("FAIL no_csum_byte rdy=%b done=%b busy=%b want 0 1 0", in_ready, done, busy);
            end
        end
        in_valid = 1'b0;
`endif
    endtask

    initial begin
        test_reset();
        test_load(1'b0, 1'b0, "basic");
        test_len_bounds();
        test_load(1'b1, 1'b0, "toggle");
        test_reset_mid_load();
        test_checksum();
        test_load(1'b0, 1'b1, "start_mid");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
